pmod_adc_block: RTL and testbench

Serial-ADC capture engine for a Pmod-style SPI ADC: the receive-side counterpart to the board's SPI DAC driver. On a `start` request it drops chip select, generates `FRAME_BITS` divided serial clocks, and shifts in ADC data MSB-first. It then presents the low `RESOLUTION` bits to the SoC with a one-cycle valid strobe. It sits between the SoC register interface and the ADC connector pins.

---
 rtl/pmod_adc_block.sv | 158 +++++++++++++++
 tb/tb_pmod_adc_block.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmod_adc_block.sv
// rtl/pmod_adc_block.sv - SPI ADC frame capture engine (optional leading-zero check: PMOD_ADC_ZERO_CHECK_EN)
module pmod_adc_block #(
    parameter int RESOLUTION   = 12,
    parameter int FRAME_BITS   = 16,
    parameter int CLK_DIV      = 2,
    parameter int QUIET_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  adc_dout_i,
    output logic [RESOLUTION-1:0] dout_o,
    output logic                  dout_valid_o,
    output logic                  busy_o,
    output logic                  frame_err_o,
    output logic                  adc_cs_n_o,
    output logic                  adc_sclk_o
);

    localparam int DIV_W   = $clog2(CLK_DIV + 1);
    localparam int BIT_W   = $clog2(FRAME_BITS + 1);
    localparam int QUIET_W = $clog2(QUIET_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_QUIET
    } state_e;

    state_e                  state_q;
    logic [DIV_W-1:0]        div_cnt_q;
    logic [BIT_W-1:0]        bit_cnt_q;
    logic [QUIET_W-1:0]      quiet_cnt_q;
    logic [FRAME_BITS-1:0]   shift_q;
    logic [FRAME_BITS-1:0]   shift_d;
    logic [RESOLUTION-1:0]   dout_q;
    logic                    dout_valid_q;
    logic                    busy_q;
    logic                    adc_cs_n_q;
    logic                    adc_sclk_q;

    logic div_last;
    logic bit_last;
    logic quiet_last;
    logic frame_done;

    assign shift_d    = (shift_q << 1) | FRAME_BITS'(adc_dout_i);
    assign div_last   = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    assign bit_last   = (bit_cnt_q == BIT_W'(FRAME_BITS - 1));
    assign quiet_last = (quiet_cnt_q == QUIET_W'(QUIET_CYCLES - 1));
    // End of the high phase of the final bit: the frame is complete in shift_q.
    assign frame_done = (state_q == S_SHIFT) && div_last && adc_sclk_q && bit_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            div_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            quiet_cnt_q  <= '0;
            shift_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            adc_cs_n_q   <= 1'b1;
            adc_sclk_q   <= 1'b1;
        end else begin
            dout_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q    <= S_SETUP;
                        adc_cs_n_q <= 1'b0;
                        busy_q     <= 1'b1;
                        div_cnt_q  <= '0;
                    end
                end
                S_SETUP: begin
                    if (div_last) begin
                        state_q    <= S_SHIFT;
                        adc_sclk_q <= 1'b0;
                        div_cnt_q  <= '0;
                        bit_cnt_q  <= '0;
                    end else begin
                        div_cnt_q <= div_cnt_q + DIV_W'(1);
                    end
                end
                S_SHIFT: begin
                    if (!div_last) begin
                        div_cnt_q <= div_cnt_q + DIV_W'(1);
                    end else begin
                        div_cnt_q <= '0;
                        if (!adc_sclk_q) begin
                            // Rising SCLK: ADC data has been stable since the falling edge.
                            adc_sclk_q <= 1'b1;
                            shift_q    <= shift_d;
                        end else if (bit_last) begin
                            state_q      <= S_QUIET;
                            adc_cs_n_q   <= 1'b1;
                            dout_q       <= shift_q[RESOLUTION-1:0];
                            dout_valid_q <= 1'b1;
                            quiet_cnt_q  <= '0;
                        end else begin
                            adc_sclk_q <= 1'b0;
                            bit_cnt_q  <= bit_cnt_q + BIT_W'(1);
                        end
                    end
                end
                S_QUIET: begin
                    if (!quiet_last) begin
                        quiet_cnt_q <= quiet_cnt_q + QUIET_W'(1);
                    end else begin
                        quiet_cnt_q <= '0;
                        if (start_i) begin
                            state_q    <= S_SETUP;
                            adc_cs_n_q <= 1'b0;
                            div_cnt_q  <= '0;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    adc_cs_n_q <= 1'b1;
                    adc_sclk_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

`ifdef PMOD_ADC_ZERO_CHECK_EN
    localparam logic [FRAME_BITS-1:0] LOW_MASK = FRAME_BITS'((64'd1 << RESOLUTION) - 64'd1);

    logic frame_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= frame_done && (|(shift_q & ~LOW_MASK));
        end
    end

    assign frame_err_o = frame_err_q;
`else
    assign frame_err_o = 1'b0;
`endif

    assign dout_o       = dout_q;
    assign dout_valid_o = dout_valid_q;
    assign busy_o       = busy_q;
    assign adc_cs_n_o   = adc_cs_n_q;
    assign adc_sclk_o   = adc_sclk_q;

endmodule

// File: tb/tb_pmod_adc_block.sv
// tb/tb_pmod_adc_block.sv - scoreboard bench for pmod_adc_block with a behavioural SPI ADC
module tb_pmod_adc_block;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        adc_dout;
    logic [11:0] dout;
    logic        dout_valid;
    logic        busy;
    logic        frame_err;
    logic        adc_cs_n;
    logic        adc_sclk;

`ifdef PMOD_ADC_ZERO_CHECK_EN
    localparam bit ZC = 1'b1;
`else
    localparam bit ZC = 1'b0;
`endif

    pmod_adc_block dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .adc_dout_i  (adc_dout),
        .dout_o      (dout),
        .dout_valid_o(dout_valid),
        .busy_o      (busy),
        .frame_err_o (frame_err),
        .adc_cs_n_o  (adc_cs_n),
        .adc_sclk_o  (adc_sclk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: loads a frame when selected, changes data on each SCLK fall.
    logic [15:0] frame_q[$];
    logic [15:0] cur_frame = 16'h0;
    int          bit_idx = 0;
    always @(negedge adc_cs_n) begin
        cur_frame = (frame_q.size() > 0) ? frame_q.pop_front() : 16'h0;
        bit_idx   = 0;
    end
    always @(negedge adc_sclk) begin
        if (!adc_cs_n && bit_idx < 16) begin
            adc_dout = cur_frame[15-bit_idx];
            bit_idx++;
        end
    end

    typedef struct {
        logic [11:0] d;
        logic        e;
    } exp_t;
    exp_t exp_q[$];

    logic [11:0] obs_dout[$];
    logic        obs_err[$];
    int          obs_t[$];
    int          runs[$];
    int          rises;
    int          stray_err;
    bit          busy_at[int];

    int checks = 0;
    int errors = 0;

    task automatic push_frame(input logic [15:0] f);
        exp_t x;
        frame_q.push_back(f);
        x.d = f[11:0];
        x.e = ZC && (f[15:12] != 4'h0);
        exp_q.push_back(x);
    endtask

    // Observation only: records what the DUT did over ncyc cycles.
    task automatic watch(input int ncyc, input int drop_at, input int poke_at);
        logic sclk_prev, csn_prev;
        int   hi_run;
        obs_dout.delete(); obs_err.delete(); obs_t.delete(); runs.delete();
        busy_at.delete();
        rises = 0; stray_err = 0; hi_run = 0;
        sclk_prev = adc_sclk; csn_prev = adc_cs_n;
        repeat (ncyc) begin
            @(negedge clk);
            if (cyc == drop_at) start = 1'b0;
            if (cyc == poke_at) start = 1'b1;
            else if (cyc == poke_at + 1) start = 1'b0;
            if (adc_sclk && !sclk_prev && !adc_cs_n) rises++;
            if (adc_cs_n) hi_run++;
            else begin
                if (csn_prev && obs_t.size() > 0) runs.push_back(hi_run);
                hi_run = 0;
            end
            if (dout_valid) begin
                obs_dout.push_back(dout); obs_err.push_back(frame_err); obs_t.push_back(cyc);
            end else if (frame_err) stray_err++;
            busy_at[cyc] = busy;
            sclk_prev = adc_sclk; csn_prev = adc_cs_n;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; adc_dout = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) begin
            @(negedge clk);
            checks++;
            if ({adc_cs_n, adc_sclk, busy, dout_valid, frame_err, dout} !== {5'b11000, 12'h000}) begin
                errors++;
                $display("FAIL reset_state cs_n=%b sclk=%b busy=%b valid=%b err=%b dout=%h want 1 1 0 0 0 000",
                         adc_cs_n, adc_sclk, busy, dout_valid, frame_err, dout);
            end
        end
    endtask

    task automatic test_single;
        int   t0;
        exp_t x;
        push_frame(16'h0ABC);
        @(negedge clk); start = 1'b1; t0 = cyc + 1;
        watch(80, t0, -1000);
        checks++;
        if (rises !== 16) begin errors++; $display("FAIL single_sclk_rises got %0d want 16", rises); end
        checks++;
        if (obs_t.size() !== 1) begin errors++; $display("FAIL single_valid_count got %0d want 1", obs_t.size()); end
        else begin
            checks++;
            if (obs_t[0] - t0 !== 66) begin errors++; $display("FAIL single_valid_time got T0+%0d want T0+66", obs_t[0] - t0); end
            x = exp_q.pop_front();
            checks++;
            if (obs_dout[0] !== x.d) begin errors++; $display("FAIL single_dout got %h want %h", obs_dout[0], x.d); end
            checks++;
            if (obs_err[0] !== x.e) begin errors++; $display("FAIL single_frame_err got %b want %b", obs_err[0], x.e); end
        end
        checks++;
        if (busy_at[t0+69] !== 1'b1 || busy_at[t0+70] !== 1'b0) begin
            errors++; $display("FAIL single_busy got %b%b at T0+69/70 want 10", busy_at[t0+69], busy_at[t0+70]);
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back;
        int          t0;
        exp_t        x;
        logic [11:0] d;
        logic        e;
        push_frame(16'h0001); push_frame(16'h0FFF); push_frame(16'h0800);
        @(negedge clk); start = 1'b1; t0 = cyc + 1;
        watch(230, t0 + 150, -1000);
        checks++;
        if (obs_t.size() !== 3) begin errors++; $display("FAIL b2b_valid_count got %0d want 3", obs_t.size()); end
        checks++;
        if (rises !== 48) begin errors++; $display("FAIL b2b_sclk_rises got %0d want 48", rises); end
        for (int i = 1; i < obs_t.size(); i++) begin
            checks++;
            if (obs_t[i] - obs_t[i-1] !== 70) begin
                errors++; $display("FAIL b2b_period frame %0d got %0d want 70", i, obs_t[i] - obs_t[i-1]);
            end
        end
        checks++;
        if (runs.size() !== 2) begin errors++; $display("FAIL b2b_gap_count got %0d want 2", runs.size()); end
        foreach (runs[i]) begin
            checks++;
            if (runs[i] !== 4) begin errors++; $display("FAIL b2b_cs_gap %0d got %0d want 4", i, runs[i]); end
        end
        while (obs_dout.size() > 0) begin
            d = obs_dout.pop_front(); e = obs_err.pop_front();
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_unexpected dout=%h want none", d); end
            else begin
                x = exp_q.pop_front();
                if (d !== x.d || e !== x.e) begin
                    errors++; $display("FAIL b2b_dout got %h/%b want %h/%b", d, e, x.d, x.e);
                end
            end
        end
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_missing got %0d left want 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_ignored_start;
        int   t0;
        exp_t x;
        push_frame(16'h0555);
        @(negedge clk); start = 1'b1; t0 = cyc + 1;
        watch(120, t0, t0 + 30);
        checks++;
        if (rises !== 16) begin errors++; $display("FAIL ignored_sclk_rises got %0d want 16", rises); end
        checks++;
        if (obs_t.size() !== 1) begin errors++; $display("FAIL ignored_valid_count got %0d want 1", obs_t.size()); end
        else begin
            x = exp_q.pop_front();
            checks++;
            if (obs_dout[0] !== x.d) begin errors++; $display("FAIL ignored_dout got %h want %h", obs_dout[0], x.d); end
        end
        checks++;
        if (busy_at[t0+119] !== 1'b0) begin errors++; $display("FAIL ignored_busy got %b want 0", busy_at[t0+119]); end
        exp_q.delete();
    endtask

    task automatic test_zero_check;
        int   t0;
        exp_t x;
        push_frame(16'h8123);
        @(negedge clk); start = 1'b1; t0 = cyc + 1;
        watch(80, t0, -1000);
        checks++;
        if (obs_t.size() !== 1) begin errors++; $display("FAIL zc_valid_count got %0d want 1", obs_t.size()); end
        else begin
            x = exp_q.pop_front();
            checks++;
            if (obs_dout[0] !== x.d) begin errors++; $display("FAIL zc_dout got %h want %h", obs_dout[0], x.d); end
            checks++;
            if (obs_err[0] !== x.e) begin errors++; $display("FAIL zc_frame_err got %b want %b", obs_err[0], x.e); end
        end
        checks++;
        if (stray_err !== 0) begin errors++; $display("FAIL zc_stray_err got %0d want 0", stray_err); end
        exp_q.delete();
    endtask

    task automatic test_reset_midframe;
        int t0;
        int n;
        int budget;
        logic sclk_prev;
        frame_q.push_back(16'h0ABC);
        @(negedge clk); start = 1'b1; t0 = cyc + 1;
        n = 0; budget = 0; sclk_prev = adc_sclk;
        while (!(n == 7 && !adc_sclk) && budget < 60) begin
            @(negedge clk);
            if (cyc == t0) start = 1'b0;
            if (adc_sclk && !sclk_prev && !adc_cs_n) n++;
            sclk_prev = adc_sclk;
            budget++;
        end
        checks++;
        if (budget >= 60) begin errors++; $display("FAIL midreset_reach got %0d rises want 7", n); end
        checks++;
        if (adc_cs_n !== 1'b0 || adc_sclk !== 1'b0) begin
            errors++; $display("FAIL midreset_pre cs_n=%b sclk=%b want 0 0", adc_cs_n, adc_sclk);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (adc_cs_n !== 1'b1 || adc_sclk !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL midreset_async cs_n=%b sclk=%b busy=%b want 1 1 0", adc_cs_n, adc_sclk, busy);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        watch(100, -1000, -1000);
        checks++;
        if (obs_t.size() !== 0 || rises !== 0) begin
            errors++; $display("FAIL midreset_no_valid got %0d valids %0d rises want 0 0", obs_t.size(), rises);
        end
        checks++;
        if (dout !== 12'h000) begin errors++; $display("FAIL midreset_dout got %h want 000", dout); end
        frame_q.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ignored_start();
        test_zero_check();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
